mbist_march_ctrl: RTL
=====================

# mbist_march_ctrl

March C- test controller for the MBIST design: the initiator that drives the single-port test memory (`fault_mem`-style model, ports `write_read/address/wdata/rdata`). It sequences every address through six March C- elements under two data backgrounds. It compensates for the memory's one-cycle write-data lead and two-cycle read latency. It compares read data and reports pass/fail, a saturating fail count and first-fail diagnostics.

## Interface
- `DATA_WIDTH`, 8: memory word width.
- `ADDR_WIDTH`, 4: memory address width.
- `CAPACITY`, 15: last valid address; tested range is 0..CAPACITY, N = CAPACITY+1.
- `CNT_WIDTH`, 8: fail counter width.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: one-cycle request, honoured only in IDLE.
- `busy`  out  1: high from the cycle after start is accepted until done.
- `done`  out  1: one-cycle pulse at test end.
- `pass`  out  1: valid from done until next accepted start; 1 = zero mismatches.
- `fail_count`  out  CNT_WIDTH: mismatching reads, saturates at all-ones.
- `first_fail_addr`  out  ADDR_WIDTH: address of first mismatch.
- `first_fail_elem`  out  4: {bg, element[2:0]} of first mismatch.
- `first_fail_data`  out  DATA_WIDTH: rdata of first mismatch.
- `write_read`  out  1: 1 = write, 0 = read.
- `address`  out  ADDR_WIDTH: memory address.
- `wdata`  out  DATA_WIDTH: write data, one cycle ahead of its write.
- `rdata`  in  DATA_WIDTH: memory read data.

## Operation
- States: IDLE → PREP (1 cycle) → RUN (20N cycles) → DRAIN (3 cycles) → DONE (1 cycle) → IDLE.
- Backgrounds: bg0 = all-zeros, bg1 = 0x55.. (repeating 01). "0" means bg, "1" means ~bg.
- Elements per background:
  - E0 ⇑(w0), E1 ⇑(r0,w1), E2 ⇑(r1,w0).
  - E3 ⇓(r0,w1), E4 ⇓(r1,w0), E5 ⇑(r0).
  - ⇕ elements run ascending.
  - ⇓ runs CAPACITY down to 0.
  - Ops within an element complete at one address before the address steps.
- Op counts: one op per RUN cycle; 10N per background; bg0 runs first, then bg1.
- Outputs by state:
  - All registered.
  - IDLE, PREP and DRAIN: `write_read`=0, `address`=0.
  - `wdata` holds its last value except where the lead rule below drives it.
- Write lead rule: `wdata` in cycle t equals the data of the op driven in cycle t+1 if that op is a write.
  - PREP exists solely to launch op 0's data.
- Read check:
  - Each read pushes {valid, expected, addr, bg, elem} into a 3-deep pipe.
  - At pipe exit, rdata ≠ expected → mismatch.
  - Every mismatch increments `fail_count` (saturating).
  - The first mismatch since start captures addr/elem/rdata.
- Result: `pass` = (fail_count==0) at DONE.
- Accepted start clears counter, diagnostics and pass.
- start outside IDLE: ignored.
- start in the DONE cycle: ignored.
- rst in any state:
  - Next state IDLE.
  - All outputs 0, including `wdata`, diagnostics, pass and `fail_count`.
  - Read pipe invalidated, no further compares.

## Timing
- start sampled high at edge E0 (IDLE).
  - PREP drives from E0.
  - Op k (k=0..20N-1) drives address/write_read from edge E0+1+k.
- Memory timing:
  - Memory samples op k at E0+2+k.
  - Read data of op k is valid on `rdata` between E0+3+k and E0+4+k.
  - Compared at edge E0+4+k.
- Last compare: at E0+20N+3.
- `done`=1 and `busy`=0 from edge E0+20N+4 for one cycle; `pass` is final at the same edge.
- `busy`=1 from E0 through E0+20N+3.
- Fail count and diagnostics update at compare edges only.

## Structure
- Package `mbist_pkg`:
  - state enum (IDLE/PREP/RUN/DRAIN/DONE).
  - element index constants E0..E5.
  - op encoding (R0,R1,W0,W1).
  - per-element op list and direction table.
  - background constants.
- Sub-module `mbist_cmp_pipe`: 3-stage expected-data pipe, comparator, saturating counter and first-fail capture.
- Top holds FSM, element/op/address sequencer and wdata lead logic.

## Test plan
- Clean memory model, CAPACITY=7:
  - start → 160 RUN cycles, done pulse at E0+164.
  - pass=1, fail_count=0.
- Sequence check, CAPACITY=7:
  - First 8 ops are writes of 0x00 to addresses 0..7.
  - Op 8 = read addr 0; op 9 = write 0xFF addr 0.
  - E3 first op = read addr 7.
  - bg1 E0 writes 0x55.
- Write-lead check: every memory write lands the intended data; monitor shadow array equals expected after each element.
- Stuck-at-1 bit 3 at addr 5 (CAPACITY=7):
  - fail_count=6 (bg0 E1/E3/E5, bg1 E1/E3/E5 reads of "0").
  - first_fail_addr=5, first_fail_elem=0x1, first_fail_data=0x08, pass=0.
- Saturation: CNT_WIDTH=2, memory forcing all reads to ~expected → fail_count=3, pass=0.
- Reset mid-RUN:
  - rst at op 40 → next cycle all outputs 0, IDLE, no done.
  - Subsequent start completes normally.
- start asserted while busy → ignored, done timing unchanged.

Source files
------------

// File: rtl/mbist_pkg.sv
// Shared types and March C- tables for the MBIST controller and its compare pipe.
package mbist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    localparam logic [2:0] E0 = 3'd0;
    localparam logic [2:0] E1 = 3'd1;
    localparam logic [2:0] E2 = 3'd2;
    localparam logic [2:0] E3 = 3'd3;
    localparam logic [2:0] E4 = 3'd4;
    localparam logic [2:0] E5 = 3'd5;

    typedef enum logic [1:0] {
        OP_R0 = 2'b00,
        OP_R1 = 2'b01,
        OP_W0 = 2'b10,
        OP_W1 = 2'b11
    } op_e;

    localparam logic [63:0] BG0_PATTERN = 64'h0000_0000_0000_0000;
    localparam logic [63:0] BG1_PATTERN = 64'h5555_5555_5555_5555;

    // Operation idx (0/1) of a March C- element.
    function automatic op_e elem_op(input logic [2:0] elem, input logic idx);
        op_e op;
        case (elem)
            E0:      op = OP_W0;
            E1, E3:  op = idx ? OP_W1 : OP_R0;
            E2, E4:  op = idx ? OP_W0 : OP_R1;
            default: op = OP_R0;
        endcase
        return op;
    endfunction

    function automatic logic elem_last_idx(input logic [2:0] elem);
        return !(elem == E0 || elem == E5);
    endfunction

    function automatic logic elem_down(input logic [2:0] elem);
        return (elem == E3 || elem == E4);
    endfunction

    function automatic logic op_is_write(input op_e op);
        return (op == OP_W0 || op == OP_W1);
    endfunction

    function automatic logic op_is_inv(input op_e op);
        return (op == OP_R1 || op == OP_W1);
    endfunction

endpackage

// File: rtl/mbist_cmp_pipe.sv
// Expected-data pipe aligned to the memory read latency, with mismatch
// counting and first-fail capture.
module mbist_cmp_pipe
    import mbist_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] exp_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  bg_i,
    input  logic [2:0]            elem_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic [CNT_WIDTH-1:0]  fail_count_o,
    output logic [ADDR_WIDTH-1:0] ff_addr_o,
    output logic [3:0]            ff_elem_o,
    output logic [DATA_WIDTH-1:0] ff_data_o
);
    localparam int unsigned DEPTH = 3;

    logic [DEPTH-1:0]      vld_q;
    logic [DATA_WIDTH-1:0] exp_q  [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [3:0]            tag_q  [DEPTH];

    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  have_fail_q;
    logic [ADDR_WIDTH-1:0] ff_addr_q;
    logic [3:0]            ff_elem_q;
    logic [DATA_WIDTH-1:0] ff_data_q;
    logic                  mismatch_c;

    assign mismatch_c = vld_q[DEPTH-1] && (rdata_i != exp_q[DEPTH-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                exp_q[i]  <= '0;
                addr_q[i] <= '0;
                tag_q[i]  <= '0;
            end
            cnt_q       <= '0;
            have_fail_q <= 1'b0;
            ff_addr_q   <= '0;
            ff_elem_q   <= '0;
            ff_data_q   <= '0;
        end else begin
            vld_q     <= {vld_q[DEPTH-2:0], push_i};
            exp_q[0]  <= exp_i;
            addr_q[0] <= addr_i;
            tag_q[0]  <= {bg_i, elem_i};
            for (int i = 1; i < DEPTH; i++) begin
                exp_q[i]  <= exp_q[i-1];
                addr_q[i] <= addr_q[i-1];
                tag_q[i]  <= tag_q[i-1];
            end
            if (clr_i) begin
                cnt_q       <= '0;
                have_fail_q <= 1'b0;
                ff_addr_q   <= '0;
                ff_elem_q   <= '0;
                ff_data_q   <= '0;
            end else if (mismatch_c) begin
                if (cnt_q != '1) cnt_q <= cnt_q + CNT_WIDTH'(1);
                if (!have_fail_q) begin
                    have_fail_q <= 1'b1;
                    ff_addr_q   <= addr_q[DEPTH-1];
                    ff_elem_q   <= tag_q[DEPTH-1];
                    ff_data_q   <= rdata_i;
                end
            end
        end
    end

    assign fail_count_o = cnt_q;
    assign ff_addr_o    = ff_addr_q;
    assign ff_elem_o    = ff_elem_q;
    assign ff_data_o    = ff_data_q;

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- MBIST controller: walks six elements under two data backgrounds and
// drives a single-port memory whose write data must lead its command by one cycle.
module mbist_march_ctrl
    import mbist_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned CAPACITY   = 15,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [CNT_WIDTH-1:0]  fail_count,
    output logic [ADDR_WIDTH-1:0] first_fail_addr,
    output logic [3:0]            first_fail_elem,
    output logic [DATA_WIDTH-1:0] first_fail_data,
    output logic                  write_read,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rdata
);
    localparam logic [ADDR_WIDTH-1:0] ADDR_TOP = ADDR_WIDTH'(CAPACITY);
    localparam int unsigned DRAIN_W      = 2;
    localparam int unsigned DRAIN_CYCLES = 3;

    state_e                state_q;
    logic                  busy_q, done_q, pass_q, wr_q, last_q;
    logic [ADDR_WIDTH-1:0] addr_out_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DRAIN_W-1:0]    drain_q;

    // Cursor: the op that will be driven at the next active edge.
    logic                  bg_q, bg_d;
    logic [2:0]            elem_q, elem_d;
    logic                  opi_q, opi_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    op_e  cur_op_c, nxt_op_c;
    logic cur_last_c, drive_c, push_c, clr_c;

    function automatic logic [DATA_WIDTH-1:0] op_data(input logic bg, input op_e op);
        logic [DATA_WIDTH-1:0] pat;
        pat = bg ? DATA_WIDTH'(BG1_PATTERN) : DATA_WIDTH'(BG0_PATTERN);
        return op_is_inv(op) ? ~pat : pat;
    endfunction

    // Advance the cursor: op within element, then address, then element/background.
    always_comb begin
        bg_d       = bg_q;
        elem_d     = elem_q;
        opi_d      = 1'b0;
        addr_d     = addr_q;
        cur_last_c = 1'b0;
        cur_op_c   = elem_op(elem_q, opi_q);
        if (opi_q != elem_last_idx(elem_q)) begin
            opi_d = 1'b1;
        end else if (addr_q != (elem_down(elem_q) ? '0 : ADDR_TOP)) begin
            addr_d = elem_down(elem_q) ? addr_q - ADDR_WIDTH'(1) : addr_q + ADDR_WIDTH'(1);
        end else begin
            if (elem_q == E5) begin
                elem_d     = E0;
                bg_d       = ~bg_q;
                cur_last_c = bg_q;
            end else begin
                elem_d = elem_q + 3'd1;
            end
            addr_d = elem_down(elem_d) ? ADDR_TOP : '0;
        end
        nxt_op_c = elem_op(elem_d, opi_d);
    end

    assign drive_c = (state_q == ST_PREP || state_q == ST_RUN) && !last_q;
    assign push_c  = drive_c && !op_is_write(cur_op_c);
    assign clr_c   = (state_q == ST_IDLE) && start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            wr_q       <= 1'b0;
            last_q     <= 1'b0;
            addr_out_q <= '0;
            wdata_q    <= '0;
            drain_q    <= '0;
            bg_q       <= 1'b0;
            elem_q     <= E0;
            opi_q      <= 1'b0;
            addr_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_PREP;
                        busy_q  <= 1'b1;
                        pass_q  <= 1'b0;
                        if (op_is_write(cur_op_c)) wdata_q <= op_data(bg_q, cur_op_c);
                    end
                end
                ST_PREP, ST_RUN: begin
                    if (last_q) begin
                        state_q    <= ST_DRAIN;
                        last_q     <= 1'b0;
                        wr_q       <= 1'b0;
                        addr_out_q <= '0;
                        drain_q    <= '0;
                    end else begin
                        state_q    <= ST_RUN;
                        wr_q       <= op_is_write(cur_op_c);
                        addr_out_q <= addr_q;
                        last_q     <= cur_last_c;
                        bg_q       <= bg_d;
                        elem_q     <= elem_d;
                        opi_q      <= opi_d;
                        addr_q     <= addr_d;
                        // After the final op the cursor wraps to op 0, whose data must not leak out.
                        if (!cur_last_c && op_is_write(nxt_op_c)) wdata_q <= op_data(bg_d, nxt_op_c);
                    end
                end
                ST_DRAIN: begin
                    drain_q <= drain_q + DRAIN_W'(1);
                    if (drain_q == DRAIN_W'(DRAIN_CYCLES - 1)) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (fail_count == '0);
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    mbist_cmp_pipe #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_cmp (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (clr_c),
        .push_i      (push_c),
        .exp_i       (op_data(bg_q, cur_op_c)),
        .addr_i      (addr_q),
        .bg_i        (bg_q),
        .elem_i      (elem_q),
        .rdata_i     (rdata),
        .fail_count_o(fail_count),
        .ff_addr_o   (first_fail_addr),
        .ff_elem_o   (first_fail_elem),
        .ff_data_o   (first_fail_data)
    );

    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign write_read = wr_q;
    assign address    = addr_out_q;
    assign wdata      = wdata_q;

endmodule
